// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: steers the HPS ioctl byte stream into four ROM regions
// and holds the core in reset until a complete, in-range image has settled.
`timescale 1ns/1ps
module rom_dl_ctrl #(
    parameter logic [15:0] R0_END        = 16'h2000,
    parameter logic [15:0] R1_END        = 16'h2800,
    parameter logic [15:0] R2_END        = 16'h3000,
    parameter logic [15:0] R3_END        = 16'h3200,
    parameter int          SETTLE_CYCLES = 256
) (
    input  logic        clk_sys,
    input  logic        Reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [13:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [3:0]  rom_we,
    output logic        core_reset_n,
    output logic        dl_busy,
    output logic        dl_error,
    output logic [15:0] byte_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0][15:0]  BOUND       = {R3_END, R2_END, R1_END, R0_END};

    logic [2:0]  state_reg, state_next;
    logic        download_prev_reg;
    logic        overflow_reg, overflow_next;
    logic [15:0] count_next;
    logic [15:0] settle_reg, settle_next;

    logic [15:0]      a;
    logic             addr_low_ok;
    logic [3:0]       hit;
    logic [3:0][13:0] rebased;
    logic [13:0]      offset;
    logic             in_range;
    logic             start_load;
    logic             wr_ok;
    logic [15:0]      count_base;
    logic             overflow_base;

    assign a           = ioctl_addr[15:0];
    assign addr_low_ok = (ioctl_addr[24:16] == 9'd0);

    // One comparator pair per region; regions are contiguous so at most one hits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_region
            if (gi == 0) begin : g_first
                assign hit[gi]     = addr_low_ok && (a < BOUND[0]);
                assign rebased[gi] = a[13:0];
            end else begin : g_rest
                assign hit[gi]     = addr_low_ok && (a >= BOUND[gi-1]) && (a < BOUND[gi]);
                assign rebased[gi] = a[13:0] - BOUND[gi-1][13:0];
            end
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = 0; k < 4; k++) begin
            if (hit[k]) begin
                offset = offset | rebased[k];
            end
        end
    end

    assign in_range = |hit;

    // A rising download in any post-load state restarts LOAD; IDLE enters on level.
    assign start_load = ioctl_download &&
                        ((state_reg == ST_IDLE) ||
                         (!download_prev_reg && ((state_reg == ST_SETTLE) ||
                                                 (state_reg == ST_RUN) ||
                                                 (state_reg == ST_ERROR))));

    assign wr_ok = ioctl_wr && ioctl_download &&
                   (start_load || (state_reg == ST_LOAD));

    assign count_base    = start_load ? 16'd0 : byte_count;
    assign overflow_base = start_load ? 1'b0  : overflow_reg;

    always_comb begin
        count_next    = count_base;
        overflow_next = overflow_base;
        if (wr_ok) begin
            if (in_range) begin
                if (count_base != 16'hFFFF) begin
                    count_next = count_base + 16'd1;
                end
            end else begin
                overflow_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_load) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (!ioctl_download) begin
                        state_next = ((byte_count == R3_END) && !overflow_reg) ? ST_SETTLE : ST_ERROR;
                    end
                end
                ST_SETTLE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    assign settle_next = ((state_reg == ST_SETTLE) && (state_next == ST_SETTLE)) ?
                         settle_reg + 16'd1 : 16'd0;

    always_ff @(posedge clk_sys) begin
        if (!Reset_n) begin
            state_reg         <= ST_IDLE;
            download_prev_reg <= 1'b0;
            overflow_reg      <= 1'b0;
            settle_reg        <= 16'd0;
            byte_count        <= 16'd0;
            rom_we            <= 4'd0;
            rom_addr          <= 14'd0;
            rom_data          <= 8'd0;
            core_reset_n      <= 1'b0;
            dl_busy           <= 1'b0;
            dl_error          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            download_prev_reg <= ioctl_download;
            overflow_reg      <= overflow_next;
            settle_reg        <= settle_next;
            byte_count        <= count_next;
            rom_we            <= (wr_ok && in_range) ? hit : 4'd0;
            if (wr_ok && in_range) begin
                rom_addr <= offset;
                rom_data <= ioctl_dout;
            end
            // Status outputs follow the next state so they change with it.
            core_reset_n      <= (state_next == ST_RUN);
            dl_busy           <= (state_next == ST_LOAD) || (state_next == ST_SETTLE);
            dl_error          <= (state_next == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Bench for rom_dl_ctrl: scoreboarded strobes, boundary vector table and
// hand-written sequences for settle timing, errors, stray writes and reset.
`timescale 1ns/1ps
module tb_rom_dl_ctrl;

    logic        clk_sys = 1'b0;
    logic        Reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rom_we;
    logic        core_reset_n;
    logic        dl_busy;
    logic        dl_error;
    logic [15:0] byte_count;

    always #5 clk_sys = ~clk_sys;

    rom_dl_ctrl dut (
        .clk_sys        (clk_sys),
        .Reset_n        (Reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .core_reset_n   (core_reset_n),
        .dl_busy        (dl_busy),
        .dl_error       (dl_error),
        .byte_count     (byte_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rcnt[4];
    bit mon_en = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [3:0]  we;
        logic [13:0] addr;
        logic [7:0]  data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [24:0] addr;
        logic [3:0]  we;
        logic [13:0] raddr;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_expect(input logic [24:0] a, input logic [7:0] d, input int due);
        sb_t e;
        logic [24:0] diff;
        e.due = due;
        e.data = d;
        if (a < 25'h2000) begin
            e.we = 4'b0001; diff = a;
        end else if (a < 25'h2800) begin
            e.we = 4'b0010; diff = a - 25'h2000;
        end else if (a < 25'h3000) begin
            e.we = 4'b0100; diff = a - 25'h2800;
        end else if (a < 25'h3200) begin
            e.we = 4'b1000; diff = a - 25'h3000;
        end else begin
            return;
        end
        e.addr = diff[13:0];
        sb.push_back(e);
    endtask

    // Strobe monitor: every strobe must match a queued expectation in its exact cycle.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                sb_t m;
                m = sb.pop_front();
                checks++; errors++;
                $display("FAIL strobe_missed due=%0d we=%b addr=%0h", m.due, m.we, m.addr);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                sb_t e;
                e = sb.pop_front();
                checks++;
                if (rom_we !== e.we || rom_addr !== e.addr || rom_data !== e.data) begin
                    errors++;
                    $display("FAIL strobe actual we=%b addr=%0h data=%0h required we=%b addr=%0h data=%0h",
                             rom_we, rom_addr, rom_data, e.we, e.addr, e.data);
                end
            end else if (rom_we !== 4'b0000) begin
                checks++; errors++;
                $display("FAIL strobe_unexpected actual we=%b required 0000 cyc=%0d", rom_we, cyc);
            end
            for (int k = 0; k < 4; k++) if (rom_we[k] === 1'b1) rcnt[k]++;
        end
    end

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (ioctl_download) push_expect(a, d, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_sys); #1;
            ioctl_wr = 1'b0;
        end
    endtask

    task automatic start_dl();
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b1;
    endtask

    task automatic drop_dl();
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
    endtask

    task automatic image(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [24:0] a;
            a = 25'(i);
            wr_byte(a, a[7:0]);
        end
    endtask

    task automatic expect_run();
        int n;
        n = 0;
        do begin
            @(posedge clk_sys); #1;
            n++;
            if (n == 1) check("settle_busy", dl_busy, 1);
            if (n == 100) check("settle_reset_low", core_reset_n, 0);
        end while (core_reset_n !== 1'b1 && n < 400);
        $display("settle: core_reset_n high after %0d cycles", n);
        check("settle_time", n, 257);
        check("run_busy", dl_busy, 0);
        check("run_error", dl_error, 0);
    endtask

    task automatic expect_error();
        @(posedge clk_sys); #1;
        check("err_flag", dl_error, 1);
        check("err_core_reset", core_reset_n, 0);
        check("err_busy", dl_busy, 0);
        idle(20);
        check("err_hold_flag", dl_error, 1);
        check("err_hold_core_reset", core_reset_n, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_cnt;

        vecs[0]  = '{25'h0000000, 4'b0001, 14'h0000};
        vecs[1]  = '{25'h0001FFF, 4'b0001, 14'h1FFF};
        vecs[2]  = '{25'h0002000, 4'b0010, 14'h0000};
        vecs[3]  = '{25'h00027FF, 4'b0010, 14'h07FF};
        vecs[4]  = '{25'h0002800, 4'b0100, 14'h0000};
        vecs[5]  = '{25'h0002FFF, 4'b0100, 14'h07FF};
        vecs[6]  = '{25'h0003000, 4'b1000, 14'h0000};
        vecs[7]  = '{25'h00031FF, 4'b1000, 14'h01FF};
        vecs[8]  = '{25'h0003200, 4'b0000, 14'h0000};
        vecs[9]  = '{25'h0010000, 4'b0000, 14'h0000};
        vecs[10] = '{25'h1FFFFFF, 4'b0000, 14'h0000};

        Reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        for (int k = 0; k < 4; k++) rcnt[k] = 0;

        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_we", rom_we, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_data", rom_data, 0);
        check("rst_core_reset", core_reset_n, 0);
        check("rst_busy", dl_busy, 0);
        check("rst_error", dl_error, 0);
        check("rst_count", byte_count, 0);
        mon_en = 1'b1;
        Reset_n = 1'b1;
        idle(3);
        check("idle_core_reset", core_reset_n, 0);

        // Full download, then settle into RUN.
        $display("seq: full download");
        start_dl();
        image(0, 32'h31FF);
        drop_dl();
        check("full_count", byte_count, 16'h3200);
        expect_run();
        check("full_r0", rcnt[0], 32'h2000);
        check("full_r1", rcnt[1], 32'h800);
        check("full_r2", rcnt[2], 32'h800);
        check("full_r3", rcnt[3], 32'h200);

        // Stray writes in RUN with download low.
        $display("seq: stray writes in RUN");
        wr_byte(25'h0000000, 8'h11);
        wr_byte(25'h0002000, 8'h22);
        wr_byte(25'h0003100, 8'h33);
        idle(2);
        check("stray_count", byte_count, 16'h3200);
        check("stray_core_reset", core_reset_n, 1);

        // Re-download from RUN with a write in the first cycle; stop one byte short.
        $display("seq: re-download, short image");
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h0;
        ioctl_dout = 8'h5A;
        push_expect(25'h0, 8'h5A, cyc + 1);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        check("redl_core_reset", core_reset_n, 0);
        check("redl_busy", dl_busy, 1);
        check("redl_count", byte_count, 1);
        image(1, 32'h31FE);
        drop_dl();
        check("short_count", byte_count, 16'h31FF);
        expect_error();

        // New full download clears the error and reaches RUN.
        $display("seq: recovery download");
        start_dl();
        @(posedge clk_sys); #1;
        check("recover_error_clear", dl_error, 0);
        check("recover_busy", dl_busy, 1);
        image(0, 32'h31FF);
        drop_dl();
        expect_run();

        // Full image followed by boundary and out-of-range vectors.
        $display("seq: boundary vectors");
        start_dl();
        image(0, 32'h31FF);
        exp_cnt = 16'h3200;
        for (int i = 0; i < 11; i++) begin
            wr_byte(vecs[i].addr, 8'(8'hA5 ^ i));
            @(posedge clk_sys); #1;
            ioctl_wr = 1'b0;
            if (vecs[i].we != 4'b0000) exp_cnt = exp_cnt + 16'd1;
            $display("vec %0d addr=%0h we=%b rom_addr=%0h count=%0h", i, vecs[i].addr, rom_we, rom_addr, byte_count);
            check("vec_we", rom_we, vecs[i].we);
            if (vecs[i].we != 4'b0000) check("vec_addr", rom_addr, vecs[i].raddr);
            check("vec_count", byte_count, exp_cnt);
        end
        drop_dl();
        check("oor_count", byte_count, 16'h3208);
        expect_error();

        // Reset in the middle of a download.
        $display("seq: reset mid-load");
        start_dl();
        image(0, 99);
        @(posedge clk_sys); #1;
        Reset_n = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        check("mid_rst_we", rom_we, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_data", rom_data, 0);
        check("mid_rst_count", byte_count, 0);
        check("mid_rst_core_reset", core_reset_n, 0);
        check("mid_rst_busy", dl_busy, 0);
        check("mid_rst_error", dl_error, 0);
        Reset_n = 1'b1;
        idle(10);
        check("post_rst_core_reset", core_reset_n, 0);
        check("post_rst_busy", dl_busy, 0);
        start_dl();
        image(0, 32'h31FF);
        drop_dl();
        expect_run();

        idle(3);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
